// File: rtl/io_input_conditioner.sv
// Board input conditioner: 2-flop sync, polarity fix, per-bit debounce.
// Produces clean active-high levels plus a rising-edge event pulse.
module io_input_conditioner #(
    parameter int                WIDTH           = 14,
    parameter int                DEBOUNCE_CYCLES = 50000,
    parameter int                CNT_WIDTH       = 16,
    parameter logic [WIDTH-1:0]  INVERT_MASK     = 14'b11_1100_0000_0000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] io_input_bus,
    output logic [WIDTH-1:0] io_event
);

    localparam int DB = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
    localparam logic [CNT_WIDTH-1:0] TERM = CNT_WIDTH'(DB - 1);

    logic [WIDTH-1:0]     sync1;
    logic [WIDTH-1:0]     sync2;
    logic [WIDTH-1:0]     p;
    logic [WIDTH-1:0]     stable_d;
    logic [WIDTH-1:0]     event_d;
    logic [CNT_WIDTH-1:0] cnt_q [WIDTH];
    logic [CNT_WIDTH-1:0] cnt_d [WIDTH];

    assign p = sync2 ^ INVERT_MASK;

    // Any sample agreeing with the stable level restarts the count
    always_comb begin
        stable_d = io_input_bus;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (p[i] != io_input_bus[i]) begin
                if (cnt_q[i] == TERM) begin
                    stable_d[i] = p[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
        event_d = stable_d & ~io_input_bus;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1        <= INVERT_MASK;
            sync2        <= INVERT_MASK;
            io_input_bus <= '0;
            io_event     <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1        <= raw_in;
            sync2        <= sync1;
            io_input_bus <= stable_d;
            io_event     <= event_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_io_input_conditioner.sv
// Bench for io_input_conditioner: window-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_io_input_conditioner;

    localparam int          W    = 14;
    localparam int          DB   = 4;
    localparam logic [13:0] MASK = 14'h3C00;
    localparam logic [13:0] IDLE = 14'h3C00;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  raw_in = 14'h0000;
    logic [W-1:0]  io_input_bus;
    logic [W-1:0]  io_event;

    int checks = 0;
    int passes = 0;

    io_input_conditioner #(
        .WIDTH(W),
        .DEBOUNCE_CYCLES(DB),
        .CNT_WIDTH(16),
        .INVERT_MASK(MASK)
    ) dut (
        .clock(clock),
        .reset(reset),
        .raw_in(raw_in),
        .io_input_bus(io_input_bus),
        .io_event(io_event)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t",
                      name, act, exp, $time);
    endtask

    // Model: raw samples travel through a 2-deep delay line; a bit flips
    // once the last DB polarity-corrected samples all disagree with it.
    logic [W-1:0] samp [$];
    logic [W-1:0] ph [$];
    logic [W-1:0] m_bus = '0;
    logic [W-1:0] m_evt = '0;
    logic [W-1:0] m_p;
    logic [W-1:0] m_nb;
    bit           m_valid = 1'b0;
    bit           all_dev;

    always @(posedge clock) begin
        if (reset) begin
            samp.delete();
            samp.push_back(MASK);
            samp.push_back(MASK);
            ph.delete();
            m_bus   = '0;
            m_evt   = '0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            m_p = samp[0] ^ MASK;
            samp.push_back(raw_in);
            void'(samp.pop_front());
            ph.push_back(m_p);
            if (ph.size() > DB) void'(ph.pop_front());
            m_nb = m_bus;
            for (int i = 0; i < W; i++) begin
                if (ph.size() == DB) begin
                    all_dev = 1'b1;
                    for (int j = 0; j < DB; j++)
                        if (ph[j][i] == m_bus[i]) all_dev = 1'b0;
                    if (all_dev) m_nb[i] = ~m_bus[i];
                end
            end
            m_evt = m_nb & ~m_bus;
            m_bus = m_nb;
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            chk("model_bus", io_input_bus, m_bus);
            chk("model_evt", io_event, m_evt);
        end
    end

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    logic [11:0] chat;
    int          evcnt;

    initial begin
        // Reset held 10 cycles with all raw pins low
        @(negedge clock);
        reset  = 1'b1;
        raw_in = 14'h0000;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("rst_bus", io_input_bus, 14'h0000);
            chk("rst_evt", io_event, 14'h0000);
        end
        reset = 1'b0;
        tick(2);
        raw_in = IDLE;
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("post_rst_bus", io_input_bus, 14'h0000);
        end

        // Switch bit 3 rise then fall
        raw_in = IDLE | 14'h0008;
        tick(5);
        chk("sw3_before", io_input_bus, 14'h0000);
        tick();
        chk("sw3_rise", io_input_bus, 14'h0008);
        chk("sw3_evt", io_event, 14'h0008);
        tick();
        chk("sw3_evt_off", io_event, 14'h0000);
        tick(2);
        raw_in = IDLE;
        tick(5);
        chk("sw3_hold", io_input_bus, 14'h0008);
        tick();
        chk("sw3_fall", io_input_bus, 14'h0000);
        chk("sw3_no_evt", io_event, 14'h0000);
        tick(3);

        // Button 10: short press rejected, long press accepted
        raw_in = IDLE & ~14'h0400;
        tick(3);
        raw_in = IDLE;
        tick(8);
        chk("btn_short", io_input_bus, 14'h0000);
        raw_in = IDLE & ~14'h0400;
        tick(6);
        chk("btn_long", io_input_bus, 14'h0400);
        chk("btn_evt", io_event, 14'h0400);
        raw_in = IDLE;
        tick(8);
        chk("btn_release", io_input_bus, 14'h0000);

        // Chatter on bit 0
        chat  = 12'b1111_1110_1101;
        evcnt = 0;
        for (int k = 0; k < 12; k++) begin
            raw_in = IDLE | {13'd0, chat[k]};
            tick();
            if (io_event[0]) evcnt++;
            if (k == 9) chk("chat_before", io_input_bus, 14'h0000);
            if (k == 10) chk("chat_rise", io_input_bus, 14'h0001);
        end
        chk("chat_evcnt", 14'(evcnt), 14'd1);
        raw_in = IDLE;
        tick(8);

        // Ten switches plus button 13 together
        raw_in = 14'h1FFF;
        tick(5);
        chk("multi_before", io_input_bus, 14'h0000);
        tick();
        chk("multi_rise", io_input_bus, 14'h23FF);
        chk("multi_evt", io_event, 14'h23FF);
        tick();
        chk("multi_evt_off", io_event, 14'h0000);
        raw_in = IDLE;
        tick(8);
        chk("multi_fall", io_input_bus, 14'h0000);

        // Reset in the middle of a count on bit 5
        raw_in = IDLE | 14'h0020;
        tick(3);
        reset = 1'b1;
        tick();
        chk("mid_rst_bus", io_input_bus, 14'h0000);
        chk("mid_rst_evt", io_event, 14'h0000);
        reset = 1'b0;
        tick(5);
        chk("mid_rst_before", io_input_bus, 14'h0000);
        tick();
        chk("mid_rst_rise", io_input_bus, 14'h0020);
        chk("mid_rst_evt2", io_event, 14'h0020);
        tick(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/io_input_conditioner.md
Name: io_input_conditioner

Overview:
- Sits directly upstream of the data memory's IO read path. It conditions the raw board inputs (10 switches, 4 push-buttons) into the clean, active-high `io_input_bus` that the memory-mapped IO block samples.
- Each bit passes through a 2-flop synchroniser, a polarity fix and a per-bit debounce counter.
- Also produces a one-cycle rising-edge pulse per bit for later interrupt/event use.

Parameters:
- WIDTH, 14, number of input bits (bits 9:0 switches, 13:10 buttons).
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a bit changes (1 ms at 50 MHz). Values below 1 are treated as 1.
- CNT_WIDTH, 16, debounce counter width. Must satisfy 2^CNT_WIDTH > DEBOUNCE_CYCLES.
- INVERT_MASK, 14'b11_1100_0000_0000, a 1 marks an active-low raw input (buttons) that is inverted after synchronisation.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- raw_in  input  WIDTH  asynchronous board pins, unsynchronised.
- io_input_bus  output  WIDTH  debounced, active-high levels; feeds the data memory.
- io_event  output  WIDTH  one-cycle pulse per bit on each debounced 0->1 transition.

Behaviour:
- One clock, and reset is synchronous and active-high; all state updates occur on posedge clock.
- Reset (`reset`=1 at an edge) sets:
  - sync1 and sync2 to INVERT_MASK (the inactive level);
  - all counters to 0;
  - `io_input_bus` to 0 and `io_event` to 0.
- Reset asserted mid-debounce discards the pending change.
- Synchroniser: sync1 <= raw_in; sync2 <= sync1. No logic between the flops.
- Polarity: p = sync2 XOR INVERT_MASK (combinational).
- Per bit i, with stable = io_input_bus[i]:
  - if p[i] == stable: cnt[i] <= 0.
  - else if cnt[i] == DEBOUNCE_CYCLES-1: stable <= p[i]; cnt[i] <= 0.
  - else: cnt[i] <= cnt[i]+1.
- Latency: a raw change first sampled by sync1 at edge E appears on `io_input_bus` after edge E+DEBOUNCE_CYCLES+1. The raw level must hold for DEBOUNCE_CYCLES+2 cycles.
- Glitch rejection: any return of p[i] to stable before the terminal count clears cnt[i]. The output does not change, and the next deviation restarts counting from 0.
- Bits are fully independent. Simultaneous changes on several bits debounce in parallel, and their counters do not interact.
- Counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- `io_event[i]` is registered, 1 exactly in the cycle after stable[i] goes 0->1, and 0 otherwise. A 1->0 transition produces no event.
- An input held active through reset produces an output rise (and an event) DEBOUNCE_CYCLES+2 cycles after reset deasserts.
- DEBOUNCE_CYCLES=1: output follows p with 1 extra cycle (total 3-edge latency), with no filtering.

Test Plan (DEBOUNCE_CYCLES=4, defaults otherwise):
- Reset with raw_in=14'h0000 held 10 cycles -> `io_input_bus`=0 and `io_event`=0 throughout, including after reset release.
- Switch raw_in[3] 0->1 at edge 0, held -> `io_input_bus`[3]=1 after edge 5 (not before); `io_event`[3]=1 for exactly the cycle after; bit 3 falls 6 edges after raw returns to 0, with no event.
- Button raw_in[10] driven 0 (pressed, active-low) for 3 cycles then 1 -> `io_input_bus`[10] stays 0 and no event; the same press held for 6 cycles -> `io_input_bus`[10]=1.
- Chatter on raw_in[0]: 1,0,1,1,0,1,1,1,1,1,… -> output rises only after 4 consecutive synchronised 1s (edge 11 relative to first sample); single `io_event`[0] pulse.
- raw_in[9:0]=10'h3FF and raw_in[13] pressed on the same edge -> all 11 bits rise on the same edge; 11 simultaneous event pulses.
- Hold raw_in[5]=1, assert `reset` at edge 3 (mid-count) for 1 cycle -> output 0 and counter cleared; bit 5 rises 6 edges after reset deasserts.
